// File: rtl/auth_tx_if.sv
// Request/status bundle between a command source and the authentication UART transmitter.
interface auth_tx_if;
    logic go;
    logic stop;
    logic TX;
    logic busy;
    logic pending;
    logic tx_done;
    logic pwr_req;

    modport master (output go, stop, input TX, busy, pending, tx_done, pwr_req);
    modport slave  (input go, stop, output TX, busy, pending, tx_done, pwr_req);
endinterface

// File: rtl/auth_tx.sv
// Serializes 'g'/'s' authentication commands as 8N1 UART frames, with one
// pending slot for back-to-back frames and a tracked far-end power request.
module auth_tx #(
    parameter int BAUD_DIV = 2604
) (
    input  logic      clk,
    input  logic      rst,
    auth_tx_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam int              BW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0]   BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [7:0]      CMD_G     = 8'h67;
    localparam logic [7:0]      CMD_S     = 8'h73;

    state_t          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            cmd_g_q, cmd_g_d;
    logic            pend_q, pend_d;
    logic            pend_g_q, pend_g_d;
    logic            tx_done_q, tx_done_d;
    logic            pwr_q, pwr_d;

    logic req, req_g, bit_end, next_g;

    // stop outranks go whenever both are seen in one cycle
    assign req     = bus.go | bus.stop;
    assign req_g   = bus.go & ~bus.stop;
    assign bit_end = (baud_q == BAUD_LAST);
    assign next_g  = req ? req_g : pend_g_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            cmd_g_q   <= 1'b0;
            pend_q    <= 1'b0;
            pend_g_q  <= 1'b0;
            tx_done_q <= 1'b0;
            pwr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            cmd_g_q   <= cmd_g_d;
            pend_q    <= pend_d;
            pend_g_q  <= pend_g_d;
            tx_done_q <= tx_done_d;
            pwr_q     <= pwr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = (state_q == IDLE || bit_end) ? '0 : baud_q + BW'(1);
        bit_d     = bit_q;
        shift_d   = shift_q;
        cmd_g_d   = cmd_g_q;
        pend_d    = pend_q;
        pend_g_d  = pend_g_q;
        tx_done_d = 1'b0;
        pwr_d     = pwr_q;

        // last request wins the single pending slot while a frame is running
        if (state_q != IDLE && req) begin
            pend_d   = 1'b1;
            pend_g_d = req_g;
        end

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = START;
                    shift_d = req_g ? CMD_G : CMD_S;
                    cmd_g_d = req_g;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    pwr_d     = cmd_g_q;
                    tx_done_d = 1'b1;
                    // a request arriving on the final stop cycle chains directly
                    if (pend_q || req) begin
                        state_d = START;
                        shift_d = next_g ? CMD_G : CMD_S;
                        cmd_g_d = next_g;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy    = (state_q != IDLE);
        bus.pending = pend_q;
        bus.tx_done = tx_done_q;
        bus.pwr_req = pwr_q;
        unique case (state_q)
            START:   bus.TX = 1'b0;
            DATA:    bus.TX = shift_q[0];
            default: bus.TX = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_auth_tx.sv
// Directed bench for auth_tx at BAUD_DIV=4: frame shape, priority, queuing, reset abort.
module tb_auth_tx;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    auth_tx_if bus();

    auth_tx #(.BAUD_DIV(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected TX trace of one frame: start, 8 data LSB first, stop; 4 cycles per bit.
    function automatic logic [39:0] expand(input logic [7:0] b);
        logic [9:0]  f;
        logic [39:0] r;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 40; i++) r[i] = f[i/4];
        return r;
    endfunction

    task automatic do_reset();
        bus.go = 1'b0; bus.stop = 1'b0;
        rst = 1'b1; tick(); tick(); rst = 1'b0;
    endtask

    task automatic launch(input logic g, input logic s);
        bus.go = g; bus.stop = s;
        tick();
        bus.go = 1'b0; bus.stop = 1'b0;
    endtask

    // Captures 40 cycles; req is {go,stop} driven at index at1/at2, go held while i<hold.
    task automatic run_frame(input int at1, input logic [1:0] r1, input int at2, input logic [1:0] r2,
                             input int hold, output logic [39:0] txv, output logic [39:0] bz,
                             output logic [39:0] pv, output int dn);
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            {bus.go, bus.stop} = (i == at1) ? r1 : (i == at2) ? r2 : 2'b00;
            if (i < hold) bus.go = 1'b1;
            txv[i] = bus.TX;
            bz[i]  = bus.busy;
            pv[i]  = bus.pending;
            if (bus.tx_done) dn++;
            tick();
        end
        bus.go = 1'b0; bus.stop = 1'b0;
    endtask

    logic [39:0] txv, bz, pv;
    int          dn, cnt;
    logic        all_hi;

    initial begin
        bus.go = 1'b0; bus.stop = 1'b0; rst = 1'b1;
        do_reset();
        chk("rst_tx", bus.TX, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_pending", bus.pending, 0);
        chk("rst_tx_done", bus.tx_done, 0);
        chk("rst_pwr", bus.pwr_req, 0);

        // single 'g'
        launch(1, 0);
        run_frame(-1, 2'b00, -1, 2'b00, 0, txv, bz, pv, dn);
        chk("g_frame", txv, expand(8'h67));
        chk("g_busy", bz, {40{1'b1}});
        chk("g_no_early_done", dn, 0);
        chk("g_done_c41", bus.tx_done, 1);
        chk("g_pwr", bus.pwr_req, 1);
        chk("g_busy_after", bus.busy, 0);
        chk("g_tx_idle", bus.TX, 1);
        tick();
        chk("g_done_1cyc", bus.tx_done, 0);

        // simultaneous go+stop
        do_reset();
        launch(1, 1);
        run_frame(-1, 2'b00, -1, 2'b00, 0, txv, bz, pv, dn);
        chk("both_frame", txv, expand(8'h73));
        chk("both_done", bus.tx_done, 1);
        chk("both_pwr", bus.pwr_req, 0);

        // queued stop 10 cycles after go
        do_reset();
        launch(1, 0);
        run_frame(9, 2'b01, -1, 2'b00, 0, txv, bz, pv, dn);
        chk("q_frame1", txv, expand(8'h67));
        chk("q_pending", pv, {{30{1'b1}}, 10'h0});
        chk("q_done1", bus.tx_done, 1);
        chk("q_pwr1", bus.pwr_req, 1);
        chk("q_pend_clr", bus.pending, 0);
        chk("q_busy_hold", bus.busy, 1);
        run_frame(-1, 2'b00, -1, 2'b00, 0, txv, bz, pv, dn);
        chk("q_frame2", txv, expand(8'h73));
        chk("q_busy2", bz, {40{1'b1}});
        chk("q_done_cnt2", dn, 1);
        chk("q_done2", bus.tx_done, 1);
        chk("q_pwr2", bus.pwr_req, 0);
        chk("q_idle", bus.busy, 0);

        // pending overwrite: stop at cycle 5, go at cycle 8
        do_reset();
        launch(1, 0);
        run_frame(4, 2'b01, 7, 2'b10, 0, txv, bz, pv, dn);
        chk("ow_frame1", txv, expand(8'h67));
        run_frame(-1, 2'b00, -1, 2'b00, 0, txv, bz, pv, dn);
        chk("ow_frame2", txv, expand(8'h67));
        chk("ow_done", bus.tx_done, 1);
        chk("ow_pwr", bus.pwr_req, 1);

        // reset during data bit 3 (cycles 17..20), with a stop queued
        do_reset();
        launch(1, 0);
        for (int i = 1; i < 18; i++) begin
            bus.stop = (i == 5);
            tick();
        end
        bus.stop = 1'b0;
        chk("ab_pend_pre", bus.pending, 1);
        chk("ab_bit3", bus.TX, 0);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("ab_tx", bus.TX, 1);
        chk("ab_busy", bus.busy, 0);
        chk("ab_pending", bus.pending, 0);
        chk("ab_pwr", bus.pwr_req, 0);
        cnt = 0; all_hi = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (bus.tx_done) cnt++;
            all_hi &= bus.TX;
            tick();
        end
        chk("ab_no_done", cnt, 0);
        chk("ab_tx_quiet", all_hi, 1);

        // go held for a whole frame yields exactly one extra frame
        do_reset();
        bus.go = 1'b1;
        tick();
        run_frame(-1, 2'b00, -1, 2'b00, 39, txv, bz, pv, dn);
        chk("hold_frame1", txv, expand(8'h67));
        chk("hold_chain", bus.busy, 1);
        run_frame(-1, 2'b00, -1, 2'b00, 0, txv, bz, pv, dn);
        chk("hold_frame2", txv, expand(8'h67));
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.busy) cnt++;
            tick();
        end
        chk("hold_no_third", cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/auth_tx.md
# auth_tx

Authentication command transmitter that drives the UART link into the rider-authentication receiver. On a `go` request it serializes 'g' (0x67); on a `stop` request it serializes 's' (0x73), both as 8N1 UART frames on `TX`. It is the host/phone-side counterpart used in the full-chip testbench and by the BLE bridge. It also tracks the power state the far end should hold after each completed frame.

## Interface
- `BAUD_DIV`, default 2604: clocks per bit (19200 baud at 50 MHz); legal range is 4 or more.
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `go` in 1: request transmission of 'g' (0x67); level-sampled each cycle.
- `stop` in 1: request transmission of 's' (0x73); level-sampled each cycle.
- `TX` out 1: UART serial output; idles high.
- `busy` out 1: a frame is in progress.
- `pending` out 1: one request is queued behind the current frame.
- `tx_done` out 1: one-cycle pulse after each frame's stop bit completes.
- `pwr_req` out 1: set when a 'g' frame completes; cleared when an 's' frame completes.

## Operation
- **Reset.** While `rst` is high at a clock edge, the block enters IDLE with `TX`=1, `busy`=0, `pending`=0, `tx_done`=0 and `pwr_req`=0. The baud counter, bit counter and shift register clear. A frame in flight is abandoned and `TX` returns high on the next edge.
- **Request decode.** On any cycle, `stop` takes priority over `go`. If both are high, the request is 's'.
- **FSM states.** IDLE, START, DATA, STOP.
- **IDLE.** On a request, load the shift register with the command byte, record the command, and go to START. `busy` goes to 1.
- **START.** `TX`=0 for BAUD_DIV cycles, then go to DATA.
- **DATA.** Send 8 bits LSB first, each held BAUD_DIV cycles. A 3-bit counter tracks the bits; after bit 7, go to STOP.
- **STOP.** `TX`=1 for BAUD_DIV cycles. On the final cycle:
  - Update `pwr_req` ('g' sets it to 1, 's' clears it to 0).
  - Pulse `tx_done` on the following cycle.
  - If `pending`=1: load the pending command, clear `pending`, and go to START.
  - Otherwise go to IDLE.
- **Requests while busy.** A request made while `busy`=1 (outside the launch cycle) is written to the single pending slot and sets `pending`. A newer request overwrites a queued one (last-wins; `stop` still beats `go` in the same cycle). No further queuing: at most one frame is ever queued.
- **Held requests.** A request held high for many cycles re-queues each cycle, so a level held across a whole frame yields exactly one extra frame. Sources should pulse.
- **Counters.** The baud counter uses ceil(log2(BAUD_DIV)) bits. It counts 0..BAUD_DIV-1 and wraps to 0 at each bit boundary, with no off-by-one. Every bit is exactly BAUD_DIV cycles.

## Timing
- **Launch.** A request sampled at edge N (block in IDLE) gives `busy`=1 and `TX`=0 from edge N+1.
- **Bit k.** Data bit k (k=0..7) occupies cycles N+1+(k+1)·BAUD_DIV through N+(k+2)·BAUD_DIV.
- **Stop bit.** Occupies cycles N+1+9·BAUD_DIV through N+10·BAUD_DIV.
- **Frame end.**
  - `tx_done`=1 for exactly one cycle, starting at edge N+1+10·BAUD_DIV.
  - `pwr_req` updates at that same edge.
  - `busy` drops at that same edge unless a pending frame launches.
- **Back-to-back frames.** With `pending`=1, the next start bit begins at edge N+1+10·BAUD_DIV with no idle gap. `busy` stays 1 and `tx_done` still pulses.
- **Frame length.** Total frame duration is 10·BAUD_DIV cycles.
- **Reset mid-frame.** Reset takes effect at the next edge regardless of state. `tx_done` does not pulse for the aborted frame.

## Test plan
Run all scenarios with `BAUD_DIV`=4 (40-cycle frames).
- **Single 'g'.** Reset, then a 1-cycle `go`. Required: `TX` sequence 0, 1,1,1,0,0,1,1,0, 1 (4 cycles each); `tx_done` pulses at cycle 41 after `go`; `pwr_req`=1; `busy` low afterwards.
- **Simultaneous requests.** `go` and `stop` in the same cycle. Required: byte 0x73 is sent; `pwr_req` stays 0.
- **Queued request.** `go` pulse, then a `stop` pulse 10 cycles later. Required:
  - `pending`=1 until the frame boundary.
  - The 0x73 start bit immediately follows the 0x67 stop bit, with no gap.
  - Two `tx_done` pulses, 40 cycles apart.
  - Final `pwr_req`=0.
- **Pending overwrite.** `go`, then `stop` at cycle 5, then `go` at cycle 8. Required: second frame is 0x67; final `pwr_req`=1.
- **Reset mid-frame.** Assert `rst` during DATA bit 3. Required: next cycle `TX`=1, `busy`=0 and `pending`=0; no `tx_done`; `pwr_req`=0.
- **Loopback.** Connect `TX` to the authentication receiver and send 'g', then 's' with `rider_off`=1. Required: receiver `pwr_up` rises after the 'g' frame and falls after the 's' frame.
